// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// FSM states, requester port indices, alignment width helper.
package dmem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DBG  = 1'b1;

  function automatic int align_bits(input int xlen);
    return $clog2(xlen / 8);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; the port that did not win last time wins a tie.
// Ports: valid[1:0], last_grant in; one-hot grant[1:0] out.
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case (1'b1)
      (valid == 2'b01): grant = 2'b01;
      (valid == 2'b10): grant = 2'b10;
      (valid == 2'b11):
        grant = (last_grant == PORT_DBG) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares data_memory between core (port 0) and debug (port 1) requesters.
// Ports: pN_* request/response per port, shared rsp_*, mem_* to data_memory.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            p0_valid,
  input  logic            p1_valid,
  output logic            p0_ready,
  output logic            p1_ready,
  input  logic            p0_write,
  input  logic            p1_write,
  input  logic [XLEN-1:0] p0_addr,
  input  logic [XLEN-1:0] p1_addr,
  input  logic [XLEN-1:0] p0_wdata,
  input  logic [XLEN-1:0] p1_wdata,
  output logic            p0_rsp_valid,
  output logic            p1_rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic [XLEN-1:0] mem_address,
  output logic [XLEN-1:0] mem_write_data,
  output logic            mem_write_en,
  output logic            mem_read_en,
  input  logic [XLEN-1:0] mem_read_data
);

  localparam int AB = align_bits(XLEN);

  state_t state, state_nx;

  logic       last_grant;
  logic [1:0] grant;
  logic       open_q;
  logic       accept;
  logic       sel;
  logic       sel_write;
  logic       aligned;
  logic       req_port;
  logic       req_write;
  logic       req_err;

  rr_arbiter2 u_rr (
    .valid      ({p1_valid, p0_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Ready is gated by reset so nothing is accepted while rst is high.
  assign open_q   = (state == IDLE) && !rst;
  assign p0_ready = open_q && grant[0];
  assign p1_ready = open_q && grant[1];
  assign accept   = p0_ready || p1_ready;

  // Outside an accept the mux parks on last_grant's port.
  assign sel = accept ? p1_ready : last_grant;

  assign mem_address    = sel ? p1_addr  : p0_addr;
  assign mem_write_data = sel ? p1_wdata : p0_wdata;
  assign sel_write      = sel ? p1_write : p0_write;
  assign aligned        = (mem_address[AB-1:0] == '0);

  assign mem_write_en = accept && sel_write && aligned;
  assign mem_read_en  = accept && !sel_write && aligned;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = WAIT;
      WAIT: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= PORT_DBG;
      req_port   <= PORT_CORE;
      req_write  <= 1'b0;
      req_err    <= 1'b0;
    end else if (accept) begin
      last_grant <= sel;
      req_port   <= sel;
      req_write  <= sel_write;
      req_err    <= !aligned;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p0_rsp_valid <= 1'b0;
      p1_rsp_valid <= 1'b0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
    end else begin
      p0_rsp_valid <= (state == WAIT) && (req_port == PORT_CORE);
      p1_rsp_valid <= (state == WAIT) && (req_port == PORT_DBG);
      if (state == WAIT) begin
        rsp_err   <= req_err;
        rsp_rdata <= (!req_write && !req_err) ? mem_read_data : '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a transaction-level model.
// Directed scenarios followed by randomized traffic on both ports.
module tb_dmem_arbiter;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            p0_valid, p1_valid;
  logic            p0_ready, p1_ready;
  logic            p0_write, p1_write;
  logic [XLEN-1:0] p0_addr, p1_addr;
  logic [XLEN-1:0] p0_wdata, p1_wdata;
  logic            p0_rsp_valid, p1_rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;
  logic [XLEN-1:0] mem_address, mem_write_data;
  logic            mem_write_en, mem_read_en;
  logic [XLEN-1:0] mem_read_data;

  dmem_arbiter #(.XLEN(XLEN)) dut (
    .clk            (clk),
    .rst            (rst),
    .p0_valid       (p0_valid),
    .p1_valid       (p1_valid),
    .p0_ready       (p0_ready),
    .p1_ready       (p1_ready),
    .p0_write       (p0_write),
    .p1_write       (p1_write),
    .p0_addr        (p0_addr),
    .p1_addr        (p1_addr),
    .p0_wdata       (p0_wdata),
    .p1_wdata       (p1_wdata),
    .p0_rsp_valid   (p0_rsp_valid),
    .p1_rsp_valid   (p1_rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_write_en   (mem_write_en),
    .mem_read_en    (mem_read_en),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  // Environment: the single-ported data_memory, 32 words.
  logic [XLEN-1:0] mem [32];

  always @(posedge clk) begin
    if (mem_write_en) mem[mem_address[7:3]] <= mem_write_data;
    if (mem_read_en)  mem_read_data <= mem[mem_address[7:3]];
  end

  // Reference model state.
  typedef struct {
    int              port;
    logic [XLEN-1:0] data;
    logic            err;
    int              due;
  } exp_t;

  logic [XLEN-1:0] ref_mem [32];
  exp_t            rq [$];
  int              glog [$];
  int              cyc;
  int              busy_until;
  int              m_last;
  logic [XLEN-1:0] m_rdata;
  logic            m_err;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag,
                     input logic [XLEN-1:0] obs,
                     input logic [XLEN-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    rq.delete();
    busy_until = -1;
    m_last     = 1;
    m_rdata    = '0;
    m_err      = 1'b0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    p0_valid = 1'b1;
    p1_valid = 1'b1;
    #1;
    chk("rst_p0_ready", p0_ready, 0);
    chk("rst_p1_ready", p1_ready, 0);
    chk("rst_wen", mem_write_en, 0);
    chk("rst_ren", mem_read_en, 0);
    @(posedge clk);
    cyc++;
    #1;
    chk("rst_p0_rsp", p0_rsp_valid, 0);
    chk("rst_p1_rsp", p1_rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    model_clear();
    rst      = 1'b0;
    p0_valid = 1'b0;
    p1_valid = 1'b0;
  endtask

  task automatic step(input logic v0, input logic w0,
                      input logic [XLEN-1:0] a0,
                      input logic [XLEN-1:0] d0,
                      input logic v1, input logic w1,
                      input logic [XLEN-1:0] a1,
                      input logic [XLEN-1:0] d1);
    logic            free, e0, e1, g, w, al;
    logic [XLEN-1:0] a, d;
    exp_t            e;
    p0_valid = v0; p0_write = w0;
    p0_addr  = a0; p0_wdata = d0;
    p1_valid = v1; p1_write = w1;
    p1_addr  = a1; p1_wdata = d1;
    #1;
    free = (cyc > busy_until);
    e0 = free && v0 && (!v1 || m_last == 1);
    e1 = free && v1 && (!v0 || m_last == 0);
    chk("p0_ready", p0_ready, e0);
    chk("p1_ready", p1_ready, e1);
    chk("ready_excl", p0_ready & p1_ready, 0);
    if (p0_ready) glog.push_back(0);
    if (p1_ready) glog.push_back(1);
    if (e0 || e1) begin
      g  = e1;
      a  = g ? a1 : a0;
      d  = g ? d1 : d0;
      w  = g ? w1 : w0;
      al = (a % 8 == 0);
      chk("mem_wen", mem_write_en, w && al);
      chk("mem_ren", mem_read_en, !w && al);
      chk("mem_addr", mem_address, a);
      if (w) chk("mem_wdata", mem_write_data, d);
      e.port = g;
      e.err  = !al;
      e.data = (w || !al) ? '0 : ref_mem[a[7:3]];
      e.due  = cyc + 2;
      if (w && al) ref_mem[a[7:3]] = d;
      rq.push_back(e);
      m_last     = g;
      busy_until = cyc + 1;
    end else begin
      chk("idle_wen", mem_write_en, 0);
      chk("idle_ren", mem_read_en, 0);
    end
    @(posedge clk);
    cyc++;
    #1;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      e = rq.pop_front();
      m_rdata = e.data;
      m_err   = e.err;
      chk("p0_rsp", p0_rsp_valid, e.port == 0);
      chk("p1_rsp", p1_rsp_valid, e.port == 1);
    end else begin
      chk("p0_rsp_idle", p0_rsp_valid, 0);
      chk("p1_rsp_idle", p1_rsp_valid, 0);
    end
    chk("rsp_rdata", rsp_rdata, m_rdata);
    chk("rsp_err", rsp_err, m_err);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [XLEN-1:0] ra0, ra1, rd0, rd1;
    logic            rv0, rv1, rw0, rw1;
    for (int i = 0; i < 32; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    mem_read_data = '0;
    cyc = 0;
    p0_write = 0; p1_write = 0;
    p0_addr = 0; p1_addr = 0;
    p0_wdata = 0; p1_wdata = 0;
    model_clear();
    do_reset();

    // Store then load on port 0.
    step(1, 1, 64'h10, 64'hDEADBEEF_CAFEF00D, 0, 0, 0, 0);
    idle(1);
    chk("st_resp", p0_rsp_valid, 1);
    chk("st_err", rsp_err, 0);
    step(1, 0, 64'h10, 0, 0, 0, 0, 0);
    idle(1);
    chk("ld_resp", p0_rsp_valid, 1);
    chk("ld_val", rsp_rdata, 64'hDEADBEEF_CAFEF00D);
    idle(1);

    // Contention: both ports reading for 8 cycles.
    do_reset();
    glog.delete();
    for (int i = 0; i < 8; i++)
      step(1, 0, 64'h10, 0, 1, 0, 64'h18, 0);
    idle(2);
    chk("glog_len", glog.size(), 4);
    if (glog.size() == 4) begin
      chk("grant0", glog[0], 0);
      chk("grant1", glog[1], 1);
      chk("grant2", glog[2], 0);
      chk("grant3", glog[3], 1);
    end

    // Misaligned load on port 1.
    step(0, 0, 0, 0, 1, 0, 64'h13, 0);
    idle(1);
    chk("mis_ld_rsp", p1_rsp_valid, 1);
    chk("mis_ld_err", rsp_err, 1);
    chk("mis_ld_data", rsp_rdata, 0);

    // Misaligned store must not touch memory.
    step(1, 1, 64'h08, 64'h5555, 0, 0, 0, 0);
    idle(1);
    step(1, 1, 64'h0C, 64'h1234, 0, 0, 0, 0);
    idle(1);
    chk("mis_st_err", rsp_err, 1);
    step(1, 0, 64'h08, 0, 0, 0, 0, 0);
    idle(1);
    chk("prior_val", rsp_rdata, 64'h5555);
    chk("prior_err", rsp_err, 0);

    // Reset during the WAIT cycle of a port 0 load.
    step(1, 0, 64'h10, 0, 0, 0, 0, 0);
    do_reset();
    idle(1);
    chk("drop_rsp", p0_rsp_valid, 0);
    step(1, 0, 64'h10, 0, 1, 0, 64'h08, 0);
    chk("post_rst_win", glog[glog.size() - 1], 0);
    idle(2);

    // Port 1 alone, held for 3 cycles.
    do_reset();
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 0, 1, 0, 64'h08, 0);
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rv0 = ($urandom_range(0, 3) != 0);
      rv1 = ($urandom_range(0, 2) != 0);
      rw0 = $urandom_range(0, 1);
      rw1 = $urandom_range(0, 1);
      ra0 = {$urandom_range(0, 31), 3'b000};
      ra1 = {$urandom_range(0, 31), 3'b000};
      if ($urandom_range(0, 3) == 0) ra0[2:0] = $urandom_range(1, 7);
      if ($urandom_range(0, 3) == 0) ra1[2:0] = $urandom_range(1, 7);
      rd0 = {$urandom, $urandom};
      rd1 = {$urandom, $urandom};
      step(rv0, rw0, ra0, rd0, rv1, rw1, ra1, rd1);
    end
    idle(3);
    chk("queue_empty", rq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-ported `data_memory` (64-bit words) between two requesters: port 0 is the core load/store path and port 1 is the debug/loader path. Arbitration is round-robin over a valid/ready request handshake. Each accepted request is issued to the memory once. Every accepted request returns exactly one response pulse on the originating port, two cycles after acceptance. Misaligned accesses are rejected with an error response and never reach the memory.

## Interface
Parameters:
- `XLEN`, 64, data and address width; the memory word is `XLEN/8` bytes.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `p0_valid`, `p1_valid`  in  1  request present on port N.
- `p0_ready`, `p1_ready`  out  1  request on port N is accepted this cycle.
- `p0_write`, `p1_write`  in  1  1 = store, 0 = load.
- `p0_addr`, `p1_addr`  in  XLEN  byte address.
- `p0_wdata`, `p1_wdata`  in  XLEN  store data.
- `p0_rsp_valid`, `p1_rsp_valid`  out  1  one-cycle response pulse to port N. There is no backpressure on responses.
- `rsp_rdata`  out  XLEN  load data. Shared by both ports; qualified by `pN_rsp_valid`.
- `rsp_err`  out  1  misaligned access. Shared; qualified by `pN_rsp_valid`.
- `mem_address`  out  XLEN  to `data_memory.address`.
- `mem_write_data`  out  XLEN  to `data_memory.write_data`.
- `mem_write_en`  out  1  to `data_memory.write_en`.
- `mem_read_en`  out  1  to `data_memory.read_en`.
- `mem_read_data`  in  XLEN  from `data_memory.read_data`; valid the cycle after `mem_read_en`.

## Operation
- FSM has two states, IDLE and WAIT; reset state is IDLE.
- **IDLE, grant selection:** grant goes to the single valid port. If both ports are valid, grant goes to the port that is not `last_grant`.
  - The granted port's `pN_ready` is 1 (combinational from valid and `last_grant`).
  - The handshake completes when `valid && ready` (accept). The accepting cycle moves the FSM to WAIT and sets `last_grant` to the granted port.
- **Memory signals in the accept cycle:** `mem_address` and `mem_write_data` are muxed from the granted port.
  - Aligned means `addr[2:0]==0`.
  - `mem_write_en = write && aligned`.
  - `mem_read_en = !write && aligned`.
  - A misaligned access drives neither enable.
- **Memory signals outside the accept cycle:** both enables are 0. `mem_address` and `mem_write_data` stay muxed from `last_grant`'s port; they are don't-care.
- **Per-request register:** the accept cycle registers `port`, `write` and `err = !aligned`.
- **WAIT:** both `pN_ready` are 0. On the clock edge:
  - `rsp_rdata` captures `mem_read_data` for an aligned load; otherwise it captures 0.
  - `rsp_err` captures the registered `err`.
  - `p<port>_rsp_valid` is set for one cycle.
  - FSM returns to IDLE.
- **Stores** also get a response, with `rsp_rdata = 0`; this lets requesters count completions.
- **Response hold:** `rsp_rdata` and `rsp_err` hold their value until the next response.
- **Requester contract:** a requester holds its address, data and write fields stable while its valid is high and ready is low. The block does not check this.

## Timing
- Cycle T: accept; memory enable asserted in T.
- Cycle T+1: FSM in WAIT; `mem_read_data` sampled at the end of T+1.
- Cycle T+2: `pN_rsp_valid` is 1 with data and error. FSM is back in IDLE, so a new accept can happen in T+2.
- Throughput is one request per 2 cycles. With both ports continuously valid, grants alternate 0,1,0,1,…
- Reset values:
  - FSM = IDLE.
  - `last_grant` = 1, so port 0 wins the first contention.
  - `p0_rsp_valid`, `p1_rsp_valid`, `rsp_err` = 0; `rsp_rdata` = 0.
  - `pN_ready`, `mem_write_en`, `mem_read_en` are 0 while `rst` is high.
- **Reset asserted mid-request:** an in-flight request (FSM in WAIT) is dropped and no response is emitted. A store accepted in the same cycle as reset assertion is not guaranteed to be written.
- **Simultaneous valid on both ports in the cycle a response is emitted:** this is legal. The response and the new accept share the cycle.

## Structure
- `dmem_arb_pkg` contains:
  - the state enum (IDLE, WAIT);
  - port index constants `PORT_CORE=0` and `PORT_DBG=1`;
  - the alignment-mask width function `$clog2(XLEN/8)`.
- Sub-module `rr_arbiter2`: a combinational two-way round-robin grant taking `valid[1:0]` and `last_grant`, producing one-hot `grant[1:0]`. It is instantiated once.
- `dmem_arbiter` holds the FSM, the request register, the response registers and the memory mux.

## Test plan
- Port 0 stores 0xDEADBEEF_CAFEF00D to 0x10, then loads 0x10:
  - the store gets a response with `rsp_err=0` at T+2;
  - the load returns 0xDEADBEEF_CAFEF00D on `p0_rsp_valid` exactly 2 cycles after acceptance.
- Both ports valid with reads for 8 cycles after reset:
  - grants go 0,1,0,1;
  - responses alternate `p0_rsp_valid`/`p1_rsp_valid` every 2 cycles;
  - the two ready signals are never high together.
- Port 1 loads 0x13:
  - `mem_read_en` and `mem_write_en` stay 0;
  - `p1_rsp_valid=1`, `rsp_err=1`, `rsp_rdata=0` at T+2.
- Port 0 misaligned store to 0x0C with data 0x1234:
  - memory is not written, and a later aligned load of 0x08 returns its prior value;
  - the store itself responds with `rsp_err=1`.
- Assert `rst` during the WAIT cycle of a port 0 load:
  - no `rsp_valid` pulse is emitted;
  - after release, port 0 wins contention against port 1 on the first cycle.
- Port 1 valid alone, held 3 cycles with `p0_valid=0`:
  - port 1 is accepted immediately despite `last_grant`;
  - `p1_ready` is low in each WAIT cycle.
